sdram_line_responder: RTL and testbench

Wishbone slave memory model that answers the SDRAM-side master port of the line cache. It accepts the cache's 4-beat line fill (read) and line flush (write) bursts, in which cycle stays asserted across all beats and the address is valid only on the first beat. It is backed by an internal word-wide block RAM with programmable per-beat wait states. It serves as bring-up memory and as the verification target for the cache's miss path.

---
 rtl/sdram_line_responder.sv | 156 +++++++++++++++
 tb/tb_sdram_line_responder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sdram_line_responder.sv
// Wishbone slave line-burst memory model: 4-beat fill/flush bursts into a word-wide RAM with per-beat wait states.
// Defining LINE_RESP_CHECK_EN adds the sticky protocol checker and the proto_err_o port.
module sdram_line_responder #(
    parameter int AW   = 12,
    parameter int WAIT = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        s_cyc_i,
    input  logic        s_stb_i,
    input  logic        s_we_i,
    input  logic [24:0] s_adr_i,
    input  logic [3:0]  s_sel_i,
    input  logic [31:0] s_dat_i,
    output logic [31:0] s_dat_o,
    output logic        s_ack_o
`ifdef LINE_RESP_CHECK_EN
    ,
    output logic        proto_err_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    localparam state_t     BEAT_ENTRY = (WAIT > 0) ? S_WAIT : S_ACK;
    localparam logic [3:0] WAIT_CNT   = 4'(WAIT);

    state_t          r_state;
    state_t          w_next;
    logic [AW-3:0]   r_base;
    logic [1:0]      r_beat;
    logic [3:0]      r_cnt;
    logic            r_we;
    logic [31:0]     r_dat;
    logic [31:0]     r_mem [0:(1<<AW)-1];

    logic            w_go;
    logic            w_wr_en;
    logic [AW-1:0]   w_rd_addr;
    logic [AW-1:0]   w_wr_addr;
    logic            w_unused;

    assign w_go     = s_cyc_i & s_stb_i;
    assign w_unused = ^{s_adr_i[24:AW], s_adr_i[1:0]};

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a low cycle aborts the burst from any state
    always_comb begin
        w_next = r_state;
        if (!s_cyc_i) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_go) w_next = BEAT_ENTRY;
                S_WAIT: if (r_cnt <= 4'd1) w_next = S_ACK;
                S_ACK: begin
                    if (r_beat == 2'd3) w_next = S_IDLE;
                    else if (w_go)      w_next = BEAT_ENTRY;
                    else                w_next = S_IDLE;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        s_ack_o = (r_state == S_ACK) & s_cyc_i;
        s_dat_o = r_dat;
    end

    // Word that becomes current on the edge entering ACK
    always_comb begin
        case (r_state)
            S_IDLE:  w_rd_addr = {s_adr_i[AW-1:2], 2'b00};
            S_ACK:   w_rd_addr = {r_base, r_beat + 2'd1};
            default: w_rd_addr = {r_base, r_beat};
        endcase
    end

    assign w_wr_addr = {r_base, r_beat};
    assign w_wr_en   = (r_state == S_ACK) & s_cyc_i & r_we & ~rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_base <= '0;
            r_beat <= '0;
            r_cnt  <= '0;
            r_we   <= 1'b0;
            r_dat  <= '0;
        end else begin
            if (r_state == S_IDLE && w_go) begin
                r_base <= s_adr_i[AW-1:2];
                r_we   <= s_we_i;
            end
            if (w_next == S_ACK) begin
                r_dat <= r_mem[w_rd_addr];
            end
            if (w_next == S_IDLE) begin
                r_beat <= '0;
            end else if (r_state == S_ACK) begin
                r_beat <= r_beat + 2'd1;
            end
            if (w_next == S_IDLE) begin
                r_cnt <= '0;
            end else if (w_next == S_WAIT && r_state != S_WAIT) begin
                r_cnt <= WAIT_CNT;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // Backing RAM: byte-lane writes, contents survive reset
    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            for (int unsigned n = 0; n < 4; n++) begin
                if (s_sel_i[n]) begin
                    r_mem[w_wr_addr][8*n +: 8] <= s_dat_i[8*n +: 8];
                end
            end
        end
    end

`ifdef LINE_RESP_CHECK_EN
    logic r_proto_err;
    logic w_trunc;
    logic w_we_flip;

    assign w_trunc   = (r_state != S_IDLE) & ~s_cyc_i & (r_beat != 2'd0);
    assign w_we_flip = (r_state != S_IDLE) & s_cyc_i & (r_beat != 2'd0) & (s_we_i != r_we);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_proto_err <= 1'b0;
        end else if (w_trunc | w_we_flip) begin
            r_proto_err <= 1'b1;
        end
    end

    assign proto_err_o = r_proto_err;
`endif

endmodule

// File: tb/tb_sdram_line_responder.sv
// Self-checking bench for sdram_line_responder: two instances (WAIT=2 and WAIT=0) against a word-array reference model.
// Build with LINE_RESP_CHECK_EN defined to also check proto_err_o.
module tb_sdram_line_responder;

    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc   [2];
    logic        stb   [2];
    logic        we_s  [2];
    logic [24:0] adr_s [2];
    logic [3:0]  sel_s [2];
    logic [31:0] dati  [2];
    logic [31:0] dato  [2];
    logic        ack   [2];
    logic        perr  [2];

    int          waits [2] = '{2, 0};
    logic [31:0] mdl   [2][DEPTH];
    bit          known [2][DEPTH];
    logic [31:0] bd    [4];
    logic [3:0]  bs    [4];
    logic [31:0] brd   [4];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    sdram_line_responder #(.AW(12), .WAIT(2)) dut (
        .clk_i(clk), .rst_i(rst), .s_cyc_i(cyc[0]), .s_stb_i(stb[0]), .s_we_i(we_s[0]),
        .s_adr_i(adr_s[0]), .s_sel_i(sel_s[0]), .s_dat_i(dati[0]), .s_dat_o(dato[0]),
        .s_ack_o(ack[0])
`ifdef LINE_RESP_CHECK_EN
        , .proto_err_o(perr[0])
`endif
    );

    sdram_line_responder #(.AW(12), .WAIT(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .s_cyc_i(cyc[1]), .s_stb_i(stb[1]), .s_we_i(we_s[1]),
        .s_adr_i(adr_s[1]), .s_sel_i(sel_s[1]), .s_dat_i(dati[1]), .s_dat_o(dato[1]),
        .s_ack_o(ack[1])
`ifdef LINE_RESP_CHECK_EN
        , .proto_err_o(perr[1])
`endif
    );

`ifndef LINE_RESP_CHECK_EN
    assign perr[0] = 1'b0;
    assign perr[1] = 1'b0;
`endif

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One burst on instance w; bd/bs hold per-beat data and lanes, brd receives s_dat_o per ack.
    // nacks < 4 drops the cycle after that many acks.
    task automatic burst(input int w, input bit we, input logic [24:0] adr, input int nacks);
        int beats = 0;
        int last  = 0;
        int n     = 0;
        int idx;
        bit adv   = 0;
        cyc[w] = 1'b1; stb[w] = 1'b1; we_s[w] = we; adr_s[w] = adr;
        dati[w] = bd[0]; sel_s[w] = bs[0];
        while (beats < nacks && n < 64) begin
            @(posedge clk); #1;
            n++;
            adr_s[w] = '0;
            if (adv) begin
                dati[w] = bd[beats]; sel_s[w] = bs[beats]; adv = 0;
            end
            #1;
            if (ack[w]) begin
                idx = (int'(adr) - int'(adr) % 4 + beats) % DEPTH;
                check_eq("ack_gap", n - last, waits[w] + 1);
                if (known[w][idx]) check_eq(we ? "wr_beat_data" : "rd_data", dato[w], mdl[w][idx]);
                brd[beats] = dato[w];
                if (we) begin
                    for (int l = 0; l < 4; l++)
                        if (bs[beats][l]) mdl[w][idx][8*l +: 8] = bd[beats][8*l +: 8];
                    if (bs[beats] == 4'hf) known[w][idx] = 1'b1;
                end
                beats++;
                last = n;
                adv  = 1;
            end
        end
        if (beats < nacks) check_eq("ack_timeout", beats, nacks);
        @(posedge clk); #1;
        cyc[w] = 1'b0; stb[w] = 1'b0; we_s[w] = 1'b0; sel_s[w] = '0; dati[w] = '0;
        #1;
        check_eq("ack_after_end", ack[w], 1'b0);
        repeat (waits[w] + 2) begin
            @(posedge clk); #2;
            if (nacks < 4) check_eq("ack_after_drop", ack[w], 1'b0);
        end
    endtask

    task automatic set_line(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                            input logic [31:0] d3, input logic [3:0] s);
        bd[0] = d0; bd[1] = d1; bd[2] = d2; bd[3] = d3;
        for (int k = 0; k < 4; k++) bs[k] = s;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int w = 0; w < 2; w++) begin
            cyc[w] = 0; stb[w] = 0; we_s[w] = 0; adr_s[w] = '0; sel_s[w] = '0; dati[w] = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int w = 0; w < 2; w++) begin
            check_eq("rst_ack", ack[w], 1'b0);
            check_eq("rst_dat", dato[w], 32'h0);
            check_eq("rst_perr", perr[w], 1'b0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // WAIT=2 write then read of line 0x100
        set_line(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 4'hf);
        burst(0, 1, 25'h000100, 4);
        burst(0, 0, 25'h000100, 4);
        check_eq("wr_rd_w0", brd[0], 32'h11111111);
        check_eq("wr_rd_w3", brd[3], 32'h44444444);

        // Partial lane write on word 0x200
        set_line(32'h12345678, 32'h0, 32'h0, 32'h0, 4'hf);
        burst(0, 1, 25'h000200, 4);
        set_line(32'hAABBCCDD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'h0);
        bs[0] = 4'b0011;
        burst(0, 1, 25'h000200, 4);
        burst(0, 0, 25'h000200, 4);
        check_eq("partial_lane", brd[0], 32'h1234CCDD);
        check_eq("no_lane_w1", brd[1], 32'h0);

        // WAIT=0 instance: back-to-back acks, beats 1-3 with address 0
        set_line(32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3, 4'hf);
        burst(1, 1, 25'h000400, 4);
        burst(1, 0, 25'h000400, 4);
        check_eq("w0_rd_w1", brd[1], 32'hA1A1A1A1);
        check_eq("w0_rd_w3", brd[3], 32'hA3A3A3A3);

        // Truncated burst on line 0x300, then a new burst there
        set_line(32'h30303030, 32'h31313131, 32'h32323232, 32'h33333333, 4'hf);
        burst(0, 1, 25'h000300, 4);
        set_line(32'h5A5A5A5A, 32'h5B5B5B5B, 32'h5C5C5C5C, 32'h5D5D5D5D, 4'hf);
        burst(0, 1, 25'h000300, 2);
`ifdef LINE_RESP_CHECK_EN
        check_eq("perr_trunc", perr[0], 1'b1);
`endif
        burst(0, 0, 25'h000300, 4);
        check_eq("trunc_w1", brd[1], 32'h5B5B5B5B);
        check_eq("trunc_w2", brd[2], 32'h32323232);

        // Address alias across bit AW
        set_line(32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 4'h0);
        bs[0] = 4'hf;
        burst(0, 1, 25'h001004, 4);
        burst(0, 0, 25'h000004, 4);
        check_eq("alias", brd[0], 32'hDEADBEEF);

        // Reset during the wait before a write beat
        set_line(32'h77777777, 32'h78787878, 32'h79797979, 32'h7A7A7A7A, 4'hf);
        burst(0, 1, 25'h000500, 4);
        burst(0, 0, 25'h000500, 4);
        cyc[0] = 1; stb[0] = 1; we_s[0] = 1; adr_s[0] = 25'h000500;
        dati[0] = 32'hFFFFFFFF; sel_s[0] = 4'hf;
        @(posedge clk); #1;
        adr_s[0] = '0;
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_mid_ack", ack[0], 1'b0);
        check_eq("rst_mid_dat", dato[0], 32'h0);
        check_eq("rst_mid_perr", perr[0], 1'b0);
        rst = 1'b0; cyc[0] = 0; stb[0] = 0; we_s[0] = 0; sel_s[0] = '0;
        repeat (4) begin
            @(posedge clk); #2;
            check_eq("rst_mid_noack", ack[0], 1'b0);
        end
        burst(0, 0, 25'h000500, 4);
        check_eq("rst_mid_word", brd[0], 32'h77777777);

        // Randomised bursts over a small aliased line pool
        for (int i = 0; i < 40; i++) begin
            int          w   = i % 2;
            bit          we  = 1'($urandom_range(0, 1));
            int          nb  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 4;
            logic [24:0] adr = 25'($urandom) & 25'h1FFF000;
            adr = adr | 25'($urandom_range(0, 7) * 64 + $urandom_range(0, 3));
            for (int k = 0; k < 4; k++) begin
                bd[k] = $urandom;
                bs[k] = ($urandom_range(0, 1) == 1) ? 4'hf : 4'($urandom_range(0, 15));
            end
            burst(w, we, adr, nb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
